// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types, constants and helpers for the result display
//
// Purpose: digit code type with its special codes, the conversion FSM state
// type, the active-low seven-segment table and the double-dabble nibble
// adjust step.
package disp_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t DIG_DASH  = 4'hA;
    localparam digit_t DIG_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        UPDATE
    } disp_state_t;

    // Indexed by digit code; {dp,g,f,e,d,c,b,a}, active-low, dp always off.
    // Unused codes (B..E) fall back to blank.
    localparam logic [7:0] SEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
    };

    // Double-dabble correction: any BCD nibble of 5 or more gets +3 so the
    // following left shift carries correctly into the next decade.
    function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
        logic [11:0] res;
        res = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - digit code to active-low seven-segment pattern
//
// Purpose: purely combinational lookup of one digit code.
// Ports:
//   code  in   4  digit code (0..9, DASH, BLANK)
//   segs  out  8  {dp,g,f,e,d,c,b,a}, active-low
module seg_decode
    import disp_pkg::*;
(
    input  digit_t     code,
    output logic [7:0] segs
);

    always_comb begin
        segs = SEG_TABLE[code];
    end

endmodule

// File: rtl/result_display.sv
// rtl/result_display.sv - captures a result, converts it to BCD and scans a 3-digit display
//
// Purpose: on a load strobe the value is captured and converted to three
// decimal digits by a bit-serial double-dabble; the digits are then
// time-multiplexed onto a common-anode seven-segment display.
// Ports:
//   sys_clk  in   1        system clock
//   sys_rst  in   1        synchronous active-high reset
//   value    in   VALUE_W  unsigned result to display
//   load     in   1        one-cycle capture strobe (ignored while busy)
//   busy     out  1        conversion in progress
//   segs     out  8        {dp,g,f,e,d,c,b,a}, active-low
//   digs     out  DIGITS   one-hot active-low digit select, bit0 rightmost
module result_display
    import disp_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int DIGITS   = 3,
    parameter int VALUE_W  = 32
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    output logic               busy,
    output logic [7:0]         segs,
    output logic [DIGITS-1:0]  digs
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    disp_state_t state_q, state_d;
    logic [11:0] bcd_q, bcd_d;
    logic [9:0]  shreg_q, shreg_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    digit_t      dig0_q, dig1_q, dig2_q;
    digit_t      dig0_d, dig1_d, dig2_d;

    logic [PW-1:0]     presc_q;
    logic [1:0]        idx_q;
    digit_t            sel_code;
    logic [7:0]        sel_segs;
    logic [DIGITS-1:0] sel_digs;

    assign busy = (state_q != IDLE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            bcd_q   <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            dig0_q  <= DIG_BLANK;
            dig1_q  <= DIG_BLANK;
            dig2_q  <= DIG_BLANK;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            dig0_q  <= dig0_d;
            dig1_q  <= dig1_d;
            dig2_q  <= dig2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        dig0_d  = dig0_q;
        dig1_d  = dig1_q;
        dig2_d  = dig2_q;

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    cnt_d = '0;
                    if (value >= VALUE_W'(1000)) begin
                        ovf_d   = 1'b1;
                        state_d = UPDATE;
                    end else begin
                        ovf_d   = 1'b0;
                        bcd_d   = '0;
                        shreg_d = value[9:0];
                        state_d = CONVERT;
                    end
                end
            end

            CONVERT: begin
                {bcd_d, shreg_d} = {bcd_adjust(bcd_q), shreg_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    state_d = UPDATE;
                end
            end

            UPDATE: begin
                // The overflow path dwells one extra cycle here so that an
                // overflowing value still gives a two-cycle busy pulse.
                if (ovf_q && cnt_q == 4'd0) begin
                    cnt_d = 4'd1;
                end else begin
                    state_d = IDLE;
                    if (ovf_q) begin
                        dig2_d = DIG_DASH;
                        dig1_d = DIG_DASH;
                        dig0_d = DIG_DASH;
                    end else begin
                        // Leading-zero blanking; the units digit always shows.
                        dig0_d = bcd_q[3:0];
                        dig1_d = (bcd_q[11:4] == 8'd0) ? DIG_BLANK : bcd_q[7:4];
                        dig2_d = (bcd_q[11:8] == 4'd0) ? DIG_BLANK : bcd_q[11:8];
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_code = DIG_BLANK;
        sel_digs = '1;
        unique case (idx_q)
            2'd0: begin
                sel_code = dig0_q;
                sel_digs = DIGITS'(3'b110);
            end
            2'd1: begin
                sel_code = dig1_q;
                sel_digs = DIGITS'(3'b101);
            end
            2'd2: begin
                sel_code = dig2_q;
                sel_digs = DIGITS'(3'b011);
            end
            default: begin
                sel_code = DIG_BLANK;
                sel_digs = '1;
            end
        endcase
    end

    seg_decode u_seg_decode (
        .code (sel_code),
        .segs (sel_segs)
    );

    // Scan runs continuously, independent of the conversion FSM.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            segs    <= 8'hFF;
            digs    <= DIGITS'(3'b110);
        end else begin
            if (presc_q == PRESC_LAST) begin
                presc_q <= '0;
                idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
            segs <= sel_segs;
            digs <= sel_digs;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - scoreboard testbench for result_display
module tb_result_display;

    localparam int SCAN_DIV = 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [31:0] value;
    logic        load;
    logic        busy;
    logic [7:0]  segs;
    logic [2:0]  digs;

    result_display #(
        .SCAN_DIV (SCAN_DIV),
        .DIGITS   (3),
        .VALUE_W  (32)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .value   (value),
        .load    (load),
        .busy    (busy),
        .segs    (segs),
        .digs    (digs)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [7:0]  len;
        logic [7:0]  s2;
        logic [7:0]  s1;
        logic [7:0]  s0;
    } exp_t;

    exp_t sb[$];
    int   total   = 0;
    int   bad     = 0;
    int   pending = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [7:0] digit_seg(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] v);
        exp_t e;
        int   h, t, u;
        if (v >= 32'd1000) begin
            e.len = 8'd2;
            e.s2 = 8'hBF;
            e.s1 = 8'hBF;
            e.s0 = 8'hBF;
        end else begin
            h = int'(v) / 100;
            t = (int'(v) / 10) % 10;
            u = int'(v) % 10;
            e.len = 8'd11;
            e.s0 = digit_seg(u);
            e.s1 = (h == 0 && t == 0) ? 8'hFF : digit_seg(t);
            e.s2 = (h == 0) ? 8'hFF : digit_seg(h);
        end
        return e;
    endfunction

    // Monitor: measures each busy pulse, then reads all three scan slots.
    int         mon_len;
    exp_t       mon_e;
    logic [7:0] got_s0, got_s1, got_s2;
    logic [2:0] seen;

    initial begin
        forever begin
            @(negedge sys_clk);
            if (busy === 1'b1) begin
                mon_len = 0;
                while (busy === 1'b1 && mon_len < 100) begin
                    mon_len++;
                    @(negedge sys_clk);
                end
                seen = 3'b000;
                got_s0 = 8'h00;
                got_s1 = 8'h00;
                got_s2 = 8'h00;
                repeat (6 * SCAN_DIV) begin
                    @(negedge sys_clk);
                    case (digs)
                        3'b110: begin got_s0 = segs; seen[0] = 1'b1; end
                        3'b101: begin got_s1 = segs; seen[1] = 1'b1; end
                        3'b011: begin got_s2 = segs; seen[2] = 1'b1; end
                        default: ;
                    endcase
                end
                if (sb.size() == 0) begin
                    check("unexpected_busy_pulse", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("busy_len", mon_len, {24'd0, mon_e.len});
                    check("slots_seen", {29'd0, seen}, 32'd7);
                    check("slot0", {24'd0, got_s0}, {24'd0, mon_e.s0});
                    check("slot1", {24'd0, got_s1}, {24'd0, mon_e.s1});
                    check("slot2", {24'd0, got_s2}, {24'd0, mon_e.s2});
                    pending--;
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic issue(input logic [31:0] v);
        sb.push_back(model(v));
        pending++;
        do_load(v);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && pending != 0; i++) begin
            tick();
        end
        check("drain", {31'd0, pending == 0}, 32'd1);
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        exp_t        e;
        int          off;

        sys_rst = 1'b1;
        value   = '0;
        load    = 1'b0;
        repeat (3) tick();
        check("rst_segs", {24'd0, segs}, 32'hFF);
        check("rst_digs", {29'd0, digs}, 32'b110);
        check("rst_busy", {31'd0, busy}, 32'd0);

        sys_rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("scan_digs", {29'd0, digs},
                  (i <= 4) ? 32'b110 : (i <= 8) ? 32'b101 : 32'b011);
            check("scan_segs_blank", {24'd0, segs}, 32'hFF);
        end

        issue(32'd123);        wait_idle();
        issue(32'd7);          wait_idle();
        issue(32'd0);          wait_idle();
        issue(32'd1000);       wait_idle();
        issue(32'hFFFF_FFFF);  wait_idle();

        // Load while busy is dropped.
        issue(32'd999);
        repeat (2) tick();
        do_load(32'd5);
        wait_idle();

        // Reset during a conversion: busy for 5 cycles, then blank display.
        e.len = 8'd5;
        e.s0 = 8'hFF;
        e.s1 = 8'hFF;
        e.s2 = 8'hFF;
        sb.push_back(e);
        pending++;
        do_load(32'd456);
        repeat (4) tick();
        sys_rst = 1'b1;
        repeat (2) tick();
        sys_rst = 1'b0;
        wait_idle();

        issue(32'd42);         wait_idle();

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 9))
                0: v = $urandom | 32'h0000_0400;
                1: v = 32'd1000;
                2: v = 32'd999;
                3: v = 32'd0;
                4: v = $urandom_range(1000, 1100);
                default: v = $urandom_range(0, 999);
            endcase
            issue(v);
            if (v < 32'd1000 && $urandom_range(0, 2) == 0) begin
                off = $urandom_range(1, 9);
                repeat (off - 1) tick();
                do_load($urandom);
            end
            wait_idle();
        end

        repeat (40) tick();
        check("no_stray_pulses", {31'd0, sb.size() == 0}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
